// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/subtract, CHUNK bits per clock through a registered carry,
// with selectable carry-in, carry/overflow/zero flags and a start/busy/done handshake
module addsub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             use_cin,
   input  logic             cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] S,
   output logic             co,
   output logic             ov,
   output logic             zero,
   output logic             busy,
   output logic             done
);
   localparam int N = WIDTH / CHUNK;
   localparam int IW = N > 1 ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("addsub_seq: WIDTH must be a multiple of CHUNK");
   end
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] a_r, b_r, s_n;
   logic [IW-1:0] idx;
   logic carry, accept, last;
   logic [CHUNK:0] sum;
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   always_comb begin
      accept = state != RUN && start;
      last = idx == LAST;
      state_n = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
      busy = state == RUN;
      done = state == DONE;
      sum = {1'b0, a_r[idx*CHUNK +: CHUNK]} + {1'b0, b_r[idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};
      s_n = S;
      s_n[idx*CHUNK +: CHUNK] = sum[CHUNK-1:0];
   end
   // overflow uses the freshly computed MSB chunk, not the stale S
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r <= '0;
         b_r <= '0;
         carry <= 1'b0;
         idx <= '0;
         S <= '0;
         co <= 1'b0;
         ov <= 1'b0;
         zero <= 1'b0;
      end else if (accept) begin
         a_r <= A;
         b_r <= sub ? ~B : B;
         carry <= use_cin ? cin : sub;
         idx <= '0;
      end else if (busy) begin
         S <= s_n;
         carry <= sum[CHUNK];
         idx <= last ? '0 : idx + 1'b1;
         if (last) begin
            co <= sum[CHUNK];
            ov <= a_r[WIDTH-1] == b_r[WIDTH-1] && sum[CHUNK-1] != a_r[WIDTH-1];
            zero <= s_n == '0;
         end
      end
   end
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: scoreboard bench for addsub_seq at CHUNK=8, 32 and 4
module tb_addsub_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sub = 1'b0, use_cin = 1'b0, cin = 1'b0;
   logic start8 = 1'b0, start32 = 1'b0, start4 = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [31:0] s8, s32, s4;
   logic co8, ov8, z8, busy8, done8;
   logic co32, ov32, z32, busy32, done32;
   logic co4, ov4, z4, busy4, done4;
   typedef struct packed {
      logic [31:0] s;
      logic co;
      logic ov;
      logic zero;
   } res_t;
   res_t q[$];
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   addsub_seq #(.WIDTH(32), .CHUNK(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub), .use_cin(use_cin), .cin(cin),
      .A(a), .B(b), .S(s8), .co(co8), .ov(ov8), .zero(z8), .busy(busy8), .done(done8));
   addsub_seq #(.WIDTH(32), .CHUNK(32)) u32 (
      .clk(clk), .rst(rst), .start(start32), .sub(sub), .use_cin(use_cin), .cin(cin),
      .A(a), .B(b), .S(s32), .co(co32), .ov(ov32), .zero(z32), .busy(busy32), .done(done32));
   addsub_seq #(.WIDTH(32), .CHUNK(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub), .use_cin(use_cin), .cin(cin),
      .A(a), .B(b), .S(s4), .co(co4), .ov(ov4), .zero(z4), .busy(busy4), .done(done4));
   function automatic res_t model(logic [31:0] ia, logic [31:0] ib, logic isub, logic iuc, logic icin);
      res_t r;
      logic [31:0] bp;
      bp = isub ? ~ib : ib;
      {r.co, r.s} = {1'b0, ia} + {1'b0, bp} + {32'd0, iuc ? icin : isub};
      r.ov = ia[31] == bp[31] && r.s[31] != ia[31];
      r.zero = r.s == 32'd0;
      return r;
   endfunction
   function automatic res_t got(int w);
      return w == 0 ? res_t'({s8, co8, ov8, z8}) : w == 1 ? res_t'({s32, co32, ov32, z32}) : res_t'({s4, co4, ov4, z4});
   endfunction
   function automatic logic dn(int w);
      return w == 0 ? done8 : w == 1 ? done32 : done4;
   endfunction
   function automatic logic bz(int w);
      return w == 0 ? busy8 : w == 1 ? busy32 : busy4;
   endfunction
   task automatic go(int w, logic [31:0] ia, logic [31:0] ib, logic isub, logic iuc, logic icin, logic push);
      a = ia;
      b = ib;
      sub = isub;
      use_cin = iuc;
      cin = icin;
      start8 = w == 0;
      start32 = w == 1;
      start4 = w == 2;
      if (push) q.push_back(model(ia, ib, isub, iuc, icin));
      @(negedge clk);
      start8 = 1'b0;
      start32 = 1'b0;
      start4 = 1'b0;
   endtask
   task automatic wait_done(int w, output int lat, output int nb);
      lat = 0;
      nb = 0;
      while (!dn(w) && lat < 40) begin
         nb += int'(bz(w));
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({s8, co8, ov8, z8, busy8, done8} !== 38'd0) begin
         errors++;
         $display("FAIL reset_outputs got S=%h co=%b ov=%b z=%b busy=%b done=%b want all 0", s8, co8, ov8, z8, busy8, done8);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_basic;
      int lat, nb;
      res_t e, r;
      go(0, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_done(0, lat, nb);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL basic_latency got %0d want 4", lat);
      end
      checks++;
      if (nb !== 4) begin
         errors++;
         $display("FAIL basic_busy_cycles got %0d want 4", nb);
      end
      e = q.pop_front();
      r = got(0);
      checks++;
      if (r !== e) begin
         errors++;
         $display("FAIL basic_result got %h want %h", r, e);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse got %b want 0", done8);
      end
   endtask
   task automatic test_arith;
      logic [31:0] va[8] = '{32'h5, 32'h0, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h0};
      logic [31:0] vb[8] = '{32'h5, 32'h1, 32'h1, 32'h1, 32'h0, 32'h0, 32'h3, 32'h0};
      logic [2:0] vm[8] = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b011, 3'b110, 3'b000};
      int lat, nb;
      res_t e, r;
      for (int i = 0; i < 14; i++) begin
         if (i < 8) go(0, va[i], vb[i], vm[i][2], vm[i][1], vm[i][0], 1'b1);
         else go(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         wait_done(0, lat, nb);
         e = q.pop_front();
         r = got(0);
         checks++;
         if (r !== e || lat !== 4) begin
            errors++;
            $display("FAIL arith_%0d got %h lat %0d want %h lat 4", i, r, lat, e);
         end
         @(negedge clk);
      end
   endtask
   task automatic test_ignore_start;
      int lat, nb;
      res_t e, r;
      go(0, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1);
      a = 32'd100;
      b = 32'd100;
      sub = 1'b1;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done(0, lat, nb);
      e = q.pop_front();
      r = got(0);
      checks++;
      if (r !== e || lat !== 3) begin
         errors++;
         $display("FAIL ignore_start_result got %h lat %0d want %h lat 3", r, lat, e);
      end
      @(negedge clk);
      checks++;
      if ({busy8, done8} !== 2'b00) begin
         errors++;
         $display("FAIL ignore_start_not_queued got busy=%b done=%b want 0 0", busy8, done8);
      end
   endtask
   task automatic test_back_to_back;
      int lat, nb;
      res_t e, r;
      go(0, 32'h10, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_done(0, lat, nb);
      e = q.pop_front();
      r = got(0);
      checks++;
      if (r !== e) begin
         errors++;
         $display("FAIL b2b_first got %h want %h", r, e);
      end
      go(0, 32'h50, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (busy8 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept got busy=%b want 1", busy8);
      end
      wait_done(0, lat, nb);
      e = q.pop_front();
      r = got(0);
      checks++;
      if (r !== e || lat !== 4) begin
         errors++;
         $display("FAIL b2b_second got %h lat %0d want %h lat 4", r, lat, e);
      end
      @(negedge clk);
   endtask
   task automatic test_abort;
      int n;
      go(0, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({s8, co8, ov8, z8, busy8, done8} !== 38'd0) begin
         errors++;
         $display("FAIL abort_reset got S=%h co=%b ov=%b z=%b busy=%b done=%b want all 0", s8, co8, ov8, z8, busy8, done8);
      end
      n = 0;
      repeat (10) begin
         @(negedge clk);
         n += int'(done8);
      end
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL abort_no_done got %0d done cycles want 0", n);
      end
   endtask
   task automatic test_chunks;
      int ws[5] = '{1, 2, 0, 2, 2};
      int wl[5] = '{1, 8, 4, 8, 8};
      logic [31:0] ca[5] = '{32'h000000FF, 32'h000000FF, 32'h00FFFFFF, 32'h00FFFFFF, 32'hFFFFFFFF};
      int lat, nb;
      res_t e, r;
      for (int i = 0; i < 5; i++) begin
         go(ws[i], ca[i], 32'h1, 1'b0, 1'b0, 1'b0, 1'b1);
         wait_done(ws[i], lat, nb);
         e = q.pop_front();
         r = got(ws[i]);
         checks++;
         if (r !== e || lat !== wl[i] || nb !== wl[i]) begin
            errors++;
            $display("FAIL chunk_%0d got %h lat %0d busy %0d want %h lat %0d", i, r, lat, nb, e, wl[i]);
         end
         @(negedge clk);
      end
   endtask
   initial begin
      test_reset;
      test_basic;
      test_arith;
      test_ignore_start;
      test_back_to_back;
      test_abort;
      test_chunks;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
